// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and a registered read port.
module param_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_DEFAULT = 6,
  parameter int AE_DEFAULT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   umbral_AF_in,
  input  logic [ADDR_WIDTH:0]   umbral_AE_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_RST   = CW'(AF_DEFAULT);
  localparam logic [CW-1:0]         AE_RST   = CW'(AE_DEFAULT);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic [CW-1:0]         af_q,     af_d;
  logic [CW-1:0]         ae_q,     ae_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;
  logic                  valid_q,  valid_d;
  logic                  ovf_q,    ovf_d;
  logic                  unf_q,    unf_d;

  logic push_ok;
  logic pop_ok;

  // Flags decode the registered count, so they never glitch on push/pop inputs.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_q);
  assign almost_empty = (count_q <= ae_q);

  assign fifo_count = count_q;
  assign data_out   = dout_q;
  assign valid_out  = valid_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

  // A pop frees a slot in the same cycle, so a push is accepted even at full.
  assign push_ok = ~init & push & (~full | pop);
  assign pop_ok  = ~init & pop & ~empty;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    af_d     = af_q;
    ae_d     = ae_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (init) begin
      af_d = umbral_AF_in;
      ae_d = umbral_AE_in;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        dout_d   = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
      end
      if (push & ~push_ok) ovf_d = 1'b1;
      if (pop & ~pop_ok)   unf_d = 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= AF_RST;
      ae_q     <= AE_RST;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_param_fifo.sv
// Table-driven bench for param_fifo: a queue model tracks stored words and a
// scoreboard queue holds the words expected on data_out.
module tb_param_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [3:0]  umbral_AF_in;
  logic [3:0]  umbral_AE_in;
  logic        push;
  logic        pop;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic        valid_out;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        underflow;

  param_fifo #(
    .DATA_WIDTH(12),
    .ADDR_WIDTH(3),
    .AF_DEFAULT(6),
    .AE_DEFAULT(0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_AF_in (umbral_AF_in),
    .umbral_AE_in (umbral_AE_in),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        init;
    logic        push;
    logic        pop;
    logic [11:0] din;
    logic [3:0]  af_in;
    logic [3:0]  ae_in;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        valid;
    logic        ovf;
    logic        unf;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        tbl[$];
  logic [11:0] mq[$];
  logic [11:0] exp_q[$];
  int          th_af = 6;
  int          th_ae = 0;
  int          split;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flag expectations follow the threshold in force after this vector's edge.
  function automatic void add(input logic i, input logic p, input logic r, input int d,
                              input int cnt, input logic v, input logic o, input logic u,
                              input int afi = 0, input int aei = 0);
    vec_t e;
    if (i) begin
      th_af = afi;
      th_ae = aei;
    end
    e.init  = i;
    e.push  = p;
    e.pop   = r;
    e.din   = 12'(d);
    e.af_in = 4'(afi);
    e.ae_in = 4'(aei);
    e.cnt   = 4'(cnt);
    e.full  = (cnt == 8);
    e.empty = (cnt == 0);
    e.af    = (cnt >= th_af);
    e.ae    = (cnt <= th_ae);
    e.valid = v;
    e.ovf   = o;
    e.unf   = u;
    tbl.push_back(e);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    bit          p_ok;
    bit          r_ok;
    logic [11:0] ed;
    init         = v.init;
    push         = v.push;
    pop          = v.pop;
    data_in      = v.din;
    umbral_AF_in = v.af_in;
    umbral_AE_in = v.ae_in;
    p_ok = !v.init && v.push && (mq.size() < 8 || v.pop);
    r_ok = !v.init && v.pop && mq.size() > 0;
    if (r_ok) exp_q.push_back(mq.pop_front());
    if (p_ok) mq.push_back(v.din);
    @(posedge clk);
    #1;
    check($sformatf("v%0d fifo_count", idx), 32'(fifo_count), 32'(v.cnt));
    check($sformatf("v%0d full", idx), 32'(full), 32'(v.full));
    check($sformatf("v%0d empty", idx), 32'(empty), 32'(v.empty));
    check($sformatf("v%0d almost_full", idx), 32'(almost_full), 32'(v.af));
    check($sformatf("v%0d almost_empty", idx), 32'(almost_empty), 32'(v.ae));
    check($sformatf("v%0d valid_out", idx), 32'(valid_out), 32'(v.valid));
    check($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.ovf));
    check($sformatf("v%0d underflow", idx), 32'(underflow), 32'(v.unf));
    if (valid_out === 1'b1) begin
      ed = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
      check($sformatf("v%0d data_out", idx), 32'(data_out), 32'(ed));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset mid-stream preamble: underflow, three pushes, one pop.
    add(0, 0, 1, 0,      0, 0, 0, 1);
    add(0, 1, 0, 'h011,  1, 0, 0, 1);
    add(0, 1, 0, 'h022,  2, 0, 0, 1);
    add(0, 1, 0, 'h033,  3, 0, 0, 1);
    add(0, 0, 1, 0,      2, 1, 0, 1);
    split = tbl.size();
    // Fill with defaults, overflow at full, drain.
    for (int i = 1; i <= 8; i++) add(0, 1, 0, i, i, 0, 0, 0);
    add(0, 1, 0, 'h0AA, 8, 0, 1, 0);
    for (int j = 1; j <= 8; j++) add(0, 0, 1, 0, 8 - j, 1, 1, 0);
    // Underflow, and push+pop on empty.
    add(0, 0, 1, 0,      0, 0, 1, 1);
    add(0, 1, 1, 'h123,  1, 0, 1, 1);
    add(0, 0, 1, 0,      0, 1, 1, 1);
    // Fill, ten simultaneous push+pop at full across pointer wrap, drain.
    for (int i = 0; i < 8; i++)  add(0, 1, 0, 'h0B0 + i, i + 1, 0, 1, 1);
    for (int k = 0; k < 10; k++) add(0, 1, 1, 'h0C0 + k, 8, 1, 1, 1);
    for (int j = 1; j <= 8; j++) add(0, 0, 1, 0, 8 - j, 1, 1, 1);
    // Init thresholds with push held, then push three.
    add(1, 1, 0, 'h555,  0, 0, 1, 1, 3, 1);
    add(0, 1, 0, 'h201,  1, 0, 1, 1);
    add(0, 1, 0, 'h202,  2, 0, 1, 1);
    add(0, 1, 0, 'h203,  3, 0, 1, 1);
    // Thresholds beyond DEPTH, pop ignored during init, then drain.
    add(1, 0, 1, 0,      3, 0, 1, 1, 15, 8);
    add(0, 0, 1, 0,      2, 1, 1, 1);
    add(0, 0, 1, 0,      1, 1, 1, 1);
    add(0, 0, 1, 0,      0, 1, 1, 1);

    reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_AF_in = '0; umbral_AE_in = '0;
    #12;
    check("rst fifo_count", 32'(fifo_count), 0);
    check("rst empty", 32'(empty), 1);
    check("rst almost_empty", 32'(almost_empty), 1);
    check("rst full", 32'(full), 0);
    check("rst almost_full", 32'(almost_full), 0);
    check("rst valid_out", 32'(valid_out), 0);
    check("rst data_out", 32'(data_out), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst underflow", 32'(underflow), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int n = 0; n < split; n++) apply(tbl[n], n);
    push = 1'b0; pop = 1'b0; init = 1'b0;

    // Asynchronous reset between edges with data held in the FIFO.
    #3 reset = 1'b1;
    #1;
    check("async fifo_count", 32'(fifo_count), 0);
    check("async empty", 32'(empty), 1);
    check("async almost_empty", 32'(almost_empty), 1);
    check("async full", 32'(full), 0);
    check("async data_out", 32'(data_out), 0);
    check("async valid_out", 32'(valid_out), 0);
    check("async overflow", 32'(overflow), 0);
    check("async underflow", 32'(underflow), 0);
    check("async scoreboard drained", 32'(exp_q.size()), 0);
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    for (int n = split; n < tbl.size(); n++) apply(tbl[n], n);
    push = 1'b0; pop = 1'b0; init = 1'b0;

    check("final scoreboard drained", 32'(exp_q.size()), 0);
    check("final model empty", 32'(mq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised synchronous FIFO.
- Generalises the 12-bit x 8-entry transaction-layer FIFO in data width and depth.
- Adds full/empty flags, an occupancy count, sticky overflow/underflow error flags and a registered read-valid.
- Serves as the common per-channel buffer between the transaction-layer referees and the downstream logic.

Parameters:
- DATA_WIDTH, 12, width of data_in/data_out.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- AF_DEFAULT, 6, almost-full threshold after reset.
- AE_DEFAULT, 0, almost-empty threshold after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  high: load thresholds; push/pop ignored this cycle.
- umbral_AF_in  in  ADDR_WIDTH+1  almost-full threshold, sampled when init=1.
- umbral_AE_in  in  ADDR_WIDTH+1  almost-empty threshold, sampled when init=1.
- push  in  1  write request.
- pop  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data, registered.
- valid_out  out  1  one-cycle pulse: data_out updated by an accepted pop.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= umbral_AF.
- almost_empty  out  1  count <= umbral_AE.
- fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - wr_ptr = rd_ptr = count = 0; data_out = 0; valid_out = 0; overflow = underflow = 0.
  - umbral_AF = AF_DEFAULT; umbral_AE = AE_DEFAULT. Memory contents are don't-care.
- Flags: full, empty, almost_full, almost_empty are combinational decodes of the registered count and thresholds.
  - Immediately after reset: empty = 1, almost_empty = 1 (0 <= 0), full = 0, almost_full = 0.
- Init: when init=1, umbral_AF/umbral_AE load from their inputs on the clock edge.
  - Pointers, count and data are unchanged; push/pop are ignored (no error flagged).
  - Thresholds take effect on flags from the next cycle.
- Storage: DEPTH x DATA_WIDTH register array, written at wr_ptr, read at rd_ptr.
  - Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Accept rules, evaluated each cycle with init=0:
  - push_ok = push & (~full | pop)
  - pop_ok = pop & ~empty
- push_ok: mem[wr_ptr] <= data_in; wr_ptr += 1.
- pop_ok: data_out <= mem[rd_ptr]; rd_ptr += 1; valid_out = 1 next cycle.
  - Otherwise valid_out = 0 and data_out holds its value.
- Read latency: data is visible on data_out one clock after the pop edge.
- Count update:
  - +1 if push_ok & ~pop_ok
  - -1 if pop_ok & ~push_ok
  - unchanged if both or neither.
- Simultaneous push & pop:
  - Not empty (including full): both proceed, count unchanged.
  - Empty: push accepted; pop rejected and underflow set. No fall-through; the new word is readable from the next cycle.
- Push while full without pop: data dropped, pointers/count unchanged, overflow <= 1.
- Pop while empty: no state change except underflow <= 1; valid_out = 0.
- Sticky errors clear only on reset.
- Threshold values above DEPTH are legal:
  - umbral_AF > DEPTH means almost_full never asserts.
  - umbral_AE >= DEPTH means almost_empty is always asserted.

Test Plan:
- Reset mid-stream: after 3 pushes, assert reset asynchronously between edges -> immediately fifo_count = 0, empty = 1, almost_empty = 1, data_out = 0, overflow = underflow = 0.
- Fill/drain with defaults: push 0x001..0x008 -> almost_full at count 6, full at count 8. Then pop 8 -> data_out sequence 0x001..0x008, each one cycle after its pop with valid_out = 1; empty = 1 at the end.
- Overflow: at full, push 0x0AA without pop -> overflow = 1, count stays 8. Draining yields 0x001..0x008; 0x0AA is never seen.
- Underflow: empty, pop -> underflow = 1, valid_out = 0. Empty, push 0x123 and pop together -> count = 1, underflow = 1; next pop returns 0x123.
- Simultaneous at full and wrap: at count 8, push 0x0BB + pop for 10 cycles -> count stays 8, full stays 1, outputs stay in order across pointer wrap; then drain 8 -> last 8 pushed values in order.
- Init thresholds: init = 1 with umbral_AF_in = 3, umbral_AE_in = 1 while push = 1 -> no push accepted. Then push 3 -> almost_empty deasserts at count 2, almost_full asserts at count 3.
